// File: rtl/cam_stream_gen.sv
// cam_stream_gen: emulated camera stream (PCLK = clk/2, HREF, VSYNC) carrying RGB444 colour bars.
// Optional macro CAM_STREAM_GEN_SCROLL_EN: bars shift by one position per completed frame.
module cam_stream_gen #(
  parameter int CAM_SCREEN_X = 160,
  parameter int CAM_SCREEN_Y = 120,
  parameter int VS_LEN       = 3,
  parameter int VB_LEN       = 4,
  parameter int H_BLANK      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       CAM_pclk,
  output logic       CAM_href,
  output logic       CAM_vsync,
  output logic [7:0] CAM_px_data,
  output logic       busy,
  output logic       frame_done
);

  localparam int XW    = (CAM_SCREEN_X > 1) ? $clog2(CAM_SCREEN_X) : 1;
  localparam int YW    = (CAM_SCREEN_Y > 1) ? $clog2(CAM_SCREEN_Y) : 1;
  localparam int BAR_W = (CAM_SCREEN_X >= 8) ? CAM_SCREEN_X / 8 : 1;
  localparam int CMAX  = (VS_LEN > VB_LEN) ? ((VS_LEN > H_BLANK) ? VS_LEN : H_BLANK)
                                           : ((VB_LEN > H_BLANK) ? VB_LEN : H_BLANK);
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [XW-1:0] X_LAST  = XW'(CAM_SCREEN_X - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(CAM_SCREEN_Y - 1);
  localparam logic [CW-1:0] VS_LAST = CW'(VS_LEN - 1);
  localparam logic [CW-1:0] VB_LAST = CW'(VB_LEN - 1);
  localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, LINE, HBLANK} state_t;

  state_t          state;
  logic [XW-1:0]   x_cnt;
  logic            byte_ph;
  logic [YW-1:0]   y_cnt;
  logic [CW-1:0]   cnt;
  logic [2:0]      ofs;

`ifdef CAM_STREAM_GEN_SCROLL_EN
  logic [2:0]      frame_cnt;
  assign ofs = frame_cnt;
`else
  assign ofs = '0;
`endif

  // First byte of a pixel carries R in the low nibble, second byte carries {G, B}.
  function automatic logic [7:0] px_byte(input logic [XW-1:0] x, input logic hi,
                                         input logic [2:0] shift);
    logic [2:0]  bar;
    logic [11:0] rgb;
    bar = 3'(int'(x) / BAR_W) + shift;
    case (bar)
      3'd0: rgb = 12'hFFF;
      3'd1: rgb = 12'hFF0;
      3'd2: rgb = 12'h0FF;
      3'd3: rgb = 12'h0F0;
      3'd4: rgb = 12'hF0F;
      3'd5: rgb = 12'hF00;
      3'd6: rgb = 12'h00F;
      3'd7: rgb = 12'h000;
    endcase
    return hi ? rgb[7:0] : {4'h0, rgb[11:8]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      CAM_pclk    <= 1'b0;
      CAM_href    <= 1'b0;
      CAM_vsync   <= 1'b0;
      CAM_px_data <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      x_cnt       <= '0;
      byte_ph     <= 1'b0;
      y_cnt       <= '0;
      cnt         <= '0;
`ifdef CAM_STREAM_GEN_SCROLL_EN
      frame_cnt   <= '0;
`endif
    end else begin
      CAM_pclk   <= ~CAM_pclk;
      frame_done <= 1'b0;
      // Everything else moves only on the PCLK falling edge (tick).
      if (CAM_pclk) begin
        case (state)
          IDLE: begin
            if (enable) begin
              state     <= VSYNC;
              CAM_vsync <= 1'b1;
              busy      <= 1'b1;
              cnt       <= '0;
            end
          end
          VSYNC: begin
            if (cnt == VS_LAST) begin
              state     <= VBACK;
              CAM_vsync <= 1'b0;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          VBACK: begin
            if (cnt == VB_LAST) begin
              state       <= LINE;
              CAM_href    <= 1'b1;
              x_cnt       <= '0;
              byte_ph     <= 1'b0;
              cnt         <= '0;
              CAM_px_data <= px_byte('0, 1'b0, ofs);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          LINE: begin
            if (!byte_ph) begin
              byte_ph     <= 1'b1;
              CAM_px_data <= px_byte(x_cnt, 1'b1, ofs);
            end else if (x_cnt == X_LAST) begin
              state       <= HBLANK;
              CAM_href    <= 1'b0;
              CAM_px_data <= '0;
              x_cnt       <= '0;
              byte_ph     <= 1'b0;
              cnt         <= '0;
            end else begin
              x_cnt       <= x_cnt + 1'b1;
              byte_ph     <= 1'b0;
              CAM_px_data <= px_byte(XW'(x_cnt + 1'b1), 1'b0, ofs);
            end
          end
          HBLANK: begin
            if (cnt == HB_LAST) begin
              cnt <= '0;
              if (y_cnt == Y_LAST) begin
                y_cnt      <= '0;
                frame_done <= 1'b1;
`ifdef CAM_STREAM_GEN_SCROLL_EN
                frame_cnt  <= frame_cnt + 1'b1;
`endif
                if (enable) begin
                  state     <= VSYNC;
                  CAM_vsync <= 1'b1;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                y_cnt       <= y_cnt + 1'b1;
                state       <= LINE;
                CAM_href    <= 1'b1;
                CAM_px_data <= px_byte('0, 1'b0, ofs);
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cam_stream_gen.sv
// Self-checking bench for cam_stream_gen: captures frames at PCLK-high samples and
// compares them with an independent colour-bar model plus timing measurements.
module tb_cam_stream_gen;

  localparam int X  = 160;
  localparam int Y  = 6;
  localparam int VS = 3;
  localparam int VB = 4;
  localparam int HB = 16;
  localparam int NB = 2 * X;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic       pclk, href, vsync, busy, frame_done;
  logic [7:0] px;

  cam_stream_gen #(
    .CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .VS_LEN(VS), .VB_LEN(VB), .H_BLANK(HB)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .CAM_pclk(pclk), .CAM_href(href), .CAM_vsync(vsync), .CAM_px_data(px),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  logic [11:0] colors [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

  function automatic logic [7:0] exp_byte(input int x, input int hi, input int shift);
    logic [11:0] rgb;
    rgb = colors[(x / (X / 8) + shift) % 8];
    return (hi != 0) ? rgb[7:0] : {4'h0, rgb[11:8]};
  endfunction

  // Monitor: one sample per PCLK-high phase (negedge clk), away from the active edge.
  logic [7:0] fbuf [Y][NB];
  int  line_bytes [Y];
  int  blank_len  [Y];
  int  line_i = 0, bidx = 0, vs_run = 0, vs_len = 0, gap_run = 0, first_gap = 0;
  int  blank_run = 0, fd_count = 0, fd_line = 0, fd_blank = 0, vs_rises = 0;
  bit  in_gap = 0, in_blank = 0, prev_vs = 0, prev_href = 0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_vs = 0; prev_href = 0; in_gap = 0; in_blank = 0; line_i = 0; bidx = 0;
    end else begin
      if (frame_done) begin
        fd_count++; fd_line = line_i; fd_blank = blank_run; in_blank = 0;
      end
      if (vsync) begin
        if (!prev_vs) begin
          vs_rises++; vs_run = 0; line_i = 0; bidx = 0; in_blank = 0; in_gap = 0;
        end
        vs_run++;
      end else if (prev_vs) begin
        vs_len = vs_run; in_gap = 1; gap_run = 1;
      end else if (in_gap && !href) begin
        gap_run++;
      end
      if (href) begin
        if (in_gap) begin first_gap = gap_run; in_gap = 0; end
        if (in_blank) begin
          if (line_i > 0 && line_i <= Y) blank_len[line_i-1] = blank_run;
          in_blank = 0;
        end
        if (pclk) begin
          if (line_i < Y && bidx < NB) fbuf[line_i][bidx] = px;
          bidx++;
        end
      end else if (prev_href) begin
        if (line_i < Y) line_bytes[line_i] = bidx;
        line_i++; bidx = 0; in_blank = 1; blank_run = 1;
      end else if (in_blank) begin
        blank_run++;
      end
      prev_vs = vsync; prev_href = href;
    end
  end

  task automatic wait_fd(input string name);
    int start;
    bit ok;
    start = fd_count;
    ok = 0;
    for (int i = 0; i < 8000 && !ok; i++) begin
      @(negedge clk); #1;
      if (fd_count != start) ok = 1;
    end
    chk({name, "_frame_done_seen"}, int'(ok), 1);
  endtask

  task automatic wait_pos(input string name, input int l, input int b);
    bit ok;
    ok = 0;
    for (int i = 0; i < 8000 && !ok; i++) begin
      @(negedge clk); #1;
      if (line_i == l && bidx >= b) ok = 1;
    end
    chk({name, "_position_reached"}, int'(ok), 1);
  endtask

  task automatic check_frame(input string tag, input int k);
    int shift, merr, lerr, berr;
    shift = 0;
`ifdef CAM_STREAM_GEN_SCROLL_EN
    shift = k % 8;
`endif
    merr = 0; lerr = 0; berr = 0;
    for (int l = 0; l < Y; l++) begin
      for (int p = 0; p < NB; p++)
        if (fbuf[l][p] !== exp_byte(p / 2, p % 2, shift)) merr++;
      if (line_bytes[l] != NB) lerr++;
      if (l < Y - 1 && blank_len[l] != 2 * HB) berr++;
    end
    chk({tag, "_pixel_map_errors"}, merr, 0);
    chk({tag, "_bad_line_byte_counts"}, lerr, 0);
    chk({tag, "_bad_hblank_lengths"}, berr, 0);
    chk({tag, "_frame_done_after_line"}, fd_line, Y);
    chk({tag, "_frame_done_blank_clk"}, fd_blank, 2 * HB);
    chk({tag, "_vsync_high_clk"}, vs_len, 2 * VS);
    chk({tag, "_vsync_to_href_clk"}, first_gap, 2 * VB);
    for (int l = 0; l < Y; l++) begin
      line_bytes[l] = -1;
      blank_len[l]  = -1;
    end
  endtask

  typedef struct {
    int         pxl;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int bad, hi_cnt, fd0, vr0;
    vecs = '{'{0, 8'h0F, 8'hFF}, '{19, 8'h0F, 8'hFF}, '{20, 8'h0F, 8'hF0},
             '{39, 8'h0F, 8'hF0}, '{40, 8'h00, 8'hFF}, '{60, 8'h00, 8'hF0},
             '{80, 8'h0F, 8'h0F}, '{100, 8'h0F, 8'h00}, '{120, 8'h00, 8'h0F},
             '{140, 8'h00, 8'h00}, '{159, 8'h00, 8'h00}};
    for (int l = 0; l < Y; l++) begin line_bytes[l] = -1; blank_len[l] = -1; end

    // Reset held with enable high: everything quiet, PCLK frozen low.
    bad = 0; hi_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if ({pclk, href, vsync, px, busy, frame_done} != '0) bad++;
      if (pclk) hi_cnt++;
    end
    chk("reset_outputs_nonzero_samples", bad, 0);
    chk("reset_pclk_high_samples", hi_cnt, 0);
    #1 rst = 1'b1;

    wait_fd("frame0");
    check_frame("frame0", 0);
    foreach (vecs[i]) begin
      chk($sformatf("line0_px%0d_byte0", vecs[i].pxl), int'(fbuf[0][2*vecs[i].pxl]), int'(vecs[i].b0));
      chk($sformatf("line0_px%0d_byte1", vecs[i].pxl), int'(fbuf[0][2*vecs[i].pxl+1]), int'(vecs[i].b1));
    end
    @(negedge clk); #1;
    chk("frame_done_one_clk", int'(frame_done), 0);
    chk("busy_between_frames", int'(busy), 1);

    for (int k = 1; k <= 8; k++) begin
      wait_fd($sformatf("frame%0d", k));
      if (k == 1 || k == 8) begin
`ifdef CAM_STREAM_GEN_SCROLL_EN
        chk($sformatf("frame%0d_px00_byte0", k), int'(fbuf[0][0]), 8'h0F);
        chk($sformatf("frame%0d_px00_byte1", k), int'(fbuf[0][1]), (k == 1) ? 8'hF0 : 8'hFF);
`else
        chk($sformatf("frame%0d_px00_byte0", k), int'(fbuf[0][0]), 8'h0F);
        chk($sformatf("frame%0d_px00_byte1", k), int'(fbuf[0][1]), 8'hFF);
`endif
      end
      check_frame($sformatf("frame%0d", k), k);
    end

    // Enable dropped mid-frame: frame still completes, then the generator idles.
    fd0 = fd_count;
    wait_pos("drop", 3, 1);
    enable = 1'b0;
    wait_fd("frame9_drop");
    check_frame("frame9_drop", 9);
    repeat (2) @(negedge clk);
    chk("busy_after_drop", int'(busy), 0);
    vr0 = vs_rises; hi_cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (busy) hi_cnt++;
    end
    chk("vsync_rises_while_idle", vs_rises - vr0, 0);
    chk("busy_samples_while_idle", hi_cnt, 0);
    chk("frame_done_pulses_drop_frame", fd_count - fd0, 1);

    // Reset mid-line: outputs clear at once, next frame is complete and unshifted.
    #1 enable = 1'b1;
    wait_pos("midreset", 1, 60);
    chk("busy_before_midreset", int'(busy), 1);
    rst = 1'b0;
    #1;
    chk("midreset_outputs", int'({pclk, href, vsync, px, busy, frame_done}), 0);
    repeat (4) @(negedge clk);
    #1 rst = 1'b1;
    wait_fd("post_reset");
    check_frame("post_reset", 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
